// File: rtl/bb_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bb_spi_pkg
// Purpose  : Shared types and constants for the busy-beaver SPI reporter.
//            Holds the FSM state enum, command codes, the status version,
//            the response frame length and the CRC-8 polynomial.
// Macro    : BB_SPI_CRC_EN - when defined, the response frame carries a
//            trailing CRC-8 byte (10 bytes instead of 9).
// Revision : 1.0 - initial release
// ============================================================================
package bb_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } bb_spi_state_e;

  localparam logic [7:0] CMD_READ       = 8'h01;
  localparam logic [7:0] CMD_RESTART    = 8'h02;
  localparam logic [6:0] BB_SPI_VERSION = 7'h01;

  // Status byte plus eight count bytes; the CRC byte (if any) follows these.
  localparam int DATA_BYTES = 9;
`ifdef BB_SPI_CRC_EN
  localparam int RESP_BYTES = 10;
`else
  localparam int RESP_BYTES = 9;
`endif
  localparam int DATA_BITS  = DATA_BYTES * 8;
  localparam int FRAME_BITS = RESP_BYTES * 8;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One MSB-first serial step of CRC-8 (no reflection).
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bb_spi_sync.sv
`default_nettype none
// ============================================================================
// Module   : bb_spi_sync
// Purpose  : Brings the asynchronous SPI pins into the clk domain and
//            derives edge strobes from the synchronised sclk and cs_n.
// Ports    : clk, rst_n        - system clock, sync active-low reset
//            sclk_i/cs_n_i/mosi_i - raw SPI pins
//            sclk_rise_o/sclk_fall_o - one-cycle strobes on synced sclk edges
//            cs_n_o            - synchronised chip select
//            cs_fall_o/cs_rise_o - one-cycle strobes on synced cs_n edges
//            mosi_o            - synchronised mosi (same depth as sclk)
// Revision : 1.0 - initial release
// ============================================================================
module bb_spi_sync
  import bb_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_n_o,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_ff_q;
  logic [SYNC_STAGES-1:0] cs_ff_q;
  logic [SYNC_STAGES-1:0] mosi_ff_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  // cs_n history resets low: if the host is still holding cs_n low when
  // reset releases, no falling edge is seen until cs_n has gone high again,
  // so a frame interrupted by reset is never resumed half-way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_ff_q   <= '0;
      cs_ff_q     <= '0;
      mosi_ff_q   <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_ff_q   <= {sclk_ff_q[SYNC_STAGES-2:0], sclk_i};
      cs_ff_q     <= {cs_ff_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_ff_q   <= {mosi_ff_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_ff_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_ff_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_o = sclk_ff_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_ff_q[SYNC_STAGES-1] & sclk_prev_q;
  assign cs_n_o      = cs_ff_q[SYNC_STAGES-1];
  assign cs_fall_o   = ~cs_ff_q[SYNC_STAGES-1] & cs_prev_q;
  assign cs_rise_o   = cs_ff_q[SYNC_STAGES-1] & ~cs_prev_q;
  assign mosi_o      = mosi_ff_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bb_spi_reporter.sv
`default_nettype none
// ============================================================================
// Module   : bb_spi_reporter
// Purpose  : SPI mode-0 responder exposing the busy-beaver core's step count
//            and halt flag to an external host, and letting the host pulse
//            the core's reset. All SPI pins are oversampled in clk.
// Ports    : clk, rst_n   - system clock, synchronous active-low reset
//            count, halt  - live core state, snapshotted at READ decode
//            sclk, cs_n, mosi - SPI pins from the host (asynchronous)
//            miso, miso_oe    - SPI data out and its tristate enable
//            bb_rst_n     - active-low reset to the core
// Macro    : BB_SPI_CRC_EN - append a serial CRC-8 byte to the READ frame.
// Revision : 1.0 - initial release
// ============================================================================
module bb_spi_reporter
  import bb_spi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int RESTART_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] count,
  input  logic        halt,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        bb_rst_n
);

  localparam int         PW           = $clog2(RESTART_CYCLES + 1);
  localparam logic [6:0] LAST_CMD_BIT = 7'd7;
  localparam logic [6:0] FRAME_END    = 7'(FRAME_BITS);
`ifdef BB_SPI_CRC_EN
  localparam logic [6:0] DATA_END     = 7'(DATA_BITS);
`endif

  logic sclk_rise;
  logic sclk_fall;
  logic cs_n_s;
  logic cs_fall;
  logic cs_rise;
  logic mosi_s;

  bb_spi_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_i      (sclk),
    .cs_n_i      (cs_n),
    .mosi_i      (mosi),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_n_o      (cs_n_s),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise),
    .mosi_o      (mosi_s)
  );

  bb_spi_state_e        state_q, state_d;
  logic [6:0]           bitcnt_q, bitcnt_d;
  logic [7:0]           cmd_q, cmd_d;
  // Snapshot of {halt, version, count}; doubles as the output shifter.
  logic [DATA_BITS-1:0] resp_q, resp_d;
  logic                 miso_q, miso_d;
  logic                 restart_req_q, restart_req_d;
  logic [PW-1:0]        pulse_q, pulse_d;
`ifdef BB_SPI_CRC_EN
  logic [7:0]           crc_q, crc_d;
`endif

  logic [7:0] cmd_shift;
  assign cmd_shift = {cmd_q[6:0], mosi_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      cmd_q         <= '0;
      resp_q        <= '0;
      miso_q        <= 1'b0;
      restart_req_q <= 1'b0;
      pulse_q       <= '0;
`ifdef BB_SPI_CRC_EN
      crc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      cmd_q         <= cmd_d;
      resp_q        <= resp_d;
      miso_q        <= miso_d;
      restart_req_q <= restart_req_d;
      pulse_q       <= pulse_d;
`ifdef BB_SPI_CRC_EN
      crc_q         <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    cmd_d         = cmd_q;
    resp_d        = resp_q;
    miso_d        = miso_q;
    restart_req_d = restart_req_q;
    pulse_d       = (pulse_q != '0) ? (pulse_q - PW'(1)) : pulse_q;
`ifdef BB_SPI_CRC_EN
    crc_d         = crc_q;
`endif

    if (cs_rise) begin
      // Deselect beats any coincident sclk edge. A pulse already running is
      // never re-armed, so a second RESTART cannot stretch it.
      state_d       = ST_IDLE;
      bitcnt_d      = '0;
      cmd_d         = '0;
      miso_d        = 1'b0;
      restart_req_d = 1'b0;
      if (restart_req_q && (pulse_q == '0)) begin
        pulse_d = PW'(RESTART_CYCLES);
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (cs_fall) begin
            state_d  = ST_CMD;
            bitcnt_d = '0;
            cmd_d    = '0;
          end
        end

        ST_CMD: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            cmd_d    = cmd_shift;
            bitcnt_d = bitcnt_q + 7'd1;
            if (bitcnt_q == LAST_CMD_BIT) begin
              bitcnt_d = '0;
              if (cmd_shift == CMD_READ) begin
                // Atomic capture in the same cycle the 8th rise is seen.
                resp_d  = {halt, BB_SPI_VERSION, count};
                state_d = ST_RESP;
`ifdef BB_SPI_CRC_EN
                crc_d   = '0;
`endif
              end else if (cmd_shift == CMD_RESTART) begin
                restart_req_d = 1'b1;
                state_d       = ST_DONE;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end

        ST_RESP: begin
          // The fall that closes the command byte already presents bit 0,
          // so each fall here puts the next frame bit on miso. The fall
          // after the last bit returns miso to 0.
          if (sclk_fall) begin
            if (bitcnt_q == FRAME_END) begin
              miso_d  = 1'b0;
              state_d = ST_DONE;
            end else begin
              bitcnt_d = bitcnt_q + 7'd1;
`ifdef BB_SPI_CRC_EN
              if (bitcnt_q < DATA_END) begin
                miso_d = resp_q[DATA_BITS-1];
                resp_d = {resp_q[DATA_BITS-2:0], 1'b0};
                crc_d  = crc8_step(crc_q, resp_q[DATA_BITS-1]);
              end else begin
                miso_d = crc_q[7];
                crc_d  = {crc_q[6:0], 1'b0};
              end
`else
              miso_d = resp_q[DATA_BITS-1];
              resp_d = {resp_q[DATA_BITS-2:0], 1'b0};
`endif
            end
          end
        end

        ST_DONE: begin
          miso_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  assign miso     = miso_q;
  // Follows synced cs_n, but only for a selection that began with a seen
  // falling edge (cs_fall covers the cycle before the FSM leaves IDLE).
  assign miso_oe  = ~cs_n_s & ((state_q != ST_IDLE) | cs_fall);
  assign bb_rst_n = rst_n & ~(pulse_q != '0);

endmodule
`default_nettype wire
